// File: rtl/obf_drain.sv
// Round-robin drain of three output FIFOs into one valid/ready result stream.
// Optional sticky FIFO-error flag enabled by defining OBF_DRAIN_ERR_EN.
module obf_drain #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned OUT_PER_LANE = 9
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      obf0_empty,
   input  logic                      obf1_empty,
   input  logic                      obf2_empty,
   input  logic [2*DATA_WIDTH-1:0]   obf0_out,
   input  logic [2*DATA_WIDTH-1:0]   obf1_out,
   input  logic [2*DATA_WIDTH-1:0]   obf2_out,
   input  logic                      obf0_err,
   input  logic                      obf1_err,
   input  logic                      obf2_err,
   output logic                      obf0_rd_en,
   output logic                      obf1_rd_en,
   output logic                      obf2_rd_en,
   output logic [2*DATA_WIDTH-1:0]   out_data,
   output logic [1:0]                out_lane,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      busy,
   output logic                      done,
   output logic                      err_flag
);

   localparam int unsigned RW = 2 * DATA_WIDTH;
   localparam int unsigned CW = $clog2(OUT_PER_LANE + 1);
   localparam logic [CW-1:0] FULL = CW'(OUT_PER_LANE);

   typedef enum logic [1:0] {IDLE, POLL, WAIT, SEND} state_e;

   state_e              state_q, state_d;
   logic [2:0][CW-1:0]  cnt_q, cnt_d;
   logic [1:0]          ptr_q, ptr_d, ptr_nxt;
   logic [RW-1:0]       data_q, data_d, lane_data;
   logic [1:0]          lane_q, lane_d;
   logic                valid_q, busy_q, done_q, done_d;
   logic [2:0]          empty_c, rd_en_c;

   assign ptr_nxt = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
   assign empty_c = {obf2_empty, obf1_empty, obf0_empty};

   always_comb begin
      case (ptr_q)
         2'd0:    lane_data = obf0_out;
         2'd1:    lane_data = obf1_out;
         default: lane_data = obf2_out;
      endcase
   end

   // Next-state, counter and read-strobe logic
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      lane_d  = lane_q;
      done_d  = 1'b0;
      rd_en_c = 3'b000;
      case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d   = '0;
               ptr_d   = 2'd0;
               state_d = POLL;
            end
         end
         POLL: begin
            if (!empty_c[ptr_q] && (cnt_q[ptr_q] < FULL)) begin
               rd_en_c[ptr_q] = 1'b1;
               state_d        = WAIT;
            end else begin
               ptr_d = ptr_nxt;
            end
         end
         WAIT: begin
            data_d  = lane_data;
            lane_d  = ptr_q;
            state_d = SEND;
         end
         SEND: begin
            if (out_ready) begin
               if (cnt_q[ptr_q] < FULL) begin
                  cnt_d[ptr_q] = cnt_q[ptr_q] + CW'(1);
               end
               ptr_d = ptr_nxt;
               if ((cnt_d[0] == FULL) && (cnt_d[1] == FULL) && (cnt_d[2] == FULL)) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = POLL;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         lane_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         lane_q  <= lane_d;
         valid_q <= (state_d == SEND);
         busy_q  <= (state_d != IDLE);
         done_q  <= done_d;
      end
   end

   assign obf0_rd_en = rd_en_c[0];
   assign obf1_rd_en = rd_en_c[1];
   assign obf2_rd_en = rd_en_c[2];
   assign out_data   = data_q;
   assign out_lane   = lane_q;
   assign out_valid  = valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

`ifdef OBF_DRAIN_ERR_EN
   logic err_q, err_d;

   // Set wins over the clear from an accepted start
   always_comb begin
      err_d = err_q;
      if ((state_q == IDLE) && start) begin
         err_d = 1'b0;
      end
      if (obf0_err || obf1_err || obf2_err) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_flag = err_q;
`else
   logic unused_err;
   assign unused_err = obf0_err ^ obf1_err ^ obf2_err;
   assign err_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_obf_drain.sv
// Directed self-checking bench for obf_drain with three queue-modelled FIFOs.
module tb_obf_drain;
   localparam int unsigned RW = 16;

`ifdef OBF_DRAIN_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, out_ready = 1'b0;
   logic obf0_empty, obf1_empty, obf2_empty;
   logic [RW-1:0] obf0_out, obf1_out, obf2_out;
   logic obf0_err = 1'b0, obf1_err = 1'b0, obf2_err = 1'b0;
   logic obf0_rd_en, obf1_rd_en, obf2_rd_en;
   logic [RW-1:0] out_data;
   logic [1:0] out_lane;
   logic out_valid, busy, done, err_flag;

   int errors = 0, checks = 0;
   int done_cnt = 0, viol = 0, rd0_cnt = 0;

   logic [RW-1:0] mem [3][256];
   int wr_ptr [3];
   int rd_ptr [3];
   logic [RW-1:0] fout [3];

   always #5 clk = ~clk;

   obf_drain dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .obf0_empty(obf0_empty), .obf1_empty(obf1_empty), .obf2_empty(obf2_empty),
      .obf0_out(obf0_out), .obf1_out(obf1_out), .obf2_out(obf2_out),
      .obf0_err(obf0_err), .obf1_err(obf1_err), .obf2_err(obf2_err),
      .obf0_rd_en(obf0_rd_en), .obf1_rd_en(obf1_rd_en), .obf2_rd_en(obf2_rd_en),
      .out_data(out_data), .out_lane(out_lane), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .done(done), .err_flag(err_flag)
   );

   // FIFO models: read data appears the cycle after rd_en
   assign obf0_empty = (wr_ptr[0] == rd_ptr[0]);
   assign obf1_empty = (wr_ptr[1] == rd_ptr[1]);
   assign obf2_empty = (wr_ptr[2] == rd_ptr[2]);
   assign obf0_out = fout[0];
   assign obf1_out = fout[1];
   assign obf2_out = fout[2];

   always @(posedge clk) begin
      if (obf0_rd_en) begin fout[0] <= mem[0][rd_ptr[0] & 255]; rd_ptr[0] <= rd_ptr[0] + 1; end
      if (obf1_rd_en) begin fout[1] <= mem[1][rd_ptr[1] & 255]; rd_ptr[1] <= rd_ptr[1] + 1; end
      if (obf2_rd_en) begin fout[2] <= mem[2][rd_ptr[2] & 255]; rd_ptr[2] <= rd_ptr[2] + 1; end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (done) done_cnt++;
         if (obf0_rd_en) rd0_cnt++;
         if ((int'(obf0_rd_en) + int'(obf1_rd_en) + int'(obf2_rd_en) > 1) ||
             ((obf0_rd_en || obf1_rd_en || obf2_rd_en) && (out_valid || !busy))) viol++;
      end
   end

   task automatic push(input int l, input logic [RW-1:0] d);
      mem[l][wr_ptr[l] & 255] = d;
      wr_ptr[l] = wr_ptr[l] + 1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
      obf0_err = 1'b0; obf1_err = 1'b0; obf2_err = 1'b0;
      for (int l = 0; l < 3; l++) wr_ptr[l] = rd_ptr[l];
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_word(output logic [RW-1:0] d, output logic [1:0] l, output bit ok);
      ok = 1'b0; d = '0; l = '0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            d = out_data; l = out_lane; ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", out_data); end
      checks++; if (out_lane !== 2'd0) begin errors++; $display("FAIL reset_lane: got %0d want 0", out_lane); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_flag); end
      checks++; if ({obf2_rd_en, obf1_rd_en, obf0_rd_en} !== 3'b000) begin errors++;
         $display("FAIL reset_rd_en: got %b want 000", {obf2_rd_en, obf1_rd_en, obf0_rd_en}); end
   endtask

   task automatic test_latency();
      bit found;
      logic [2:0] rdv;
      apply_reset();
      push(0, 16'h1234);
      pulse_start();
      found = 1'b0; rdv = '0;
      for (int i = 0; i < 20; i++) begin
         if (obf0_rd_en) begin found = 1'b1; rdv = {obf2_rd_en, obf1_rd_en, obf0_rd_en}; break; end
         @(negedge clk);
      end
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL lat_rd_seen: got %b want 1", found); end
      checks++; if (rdv !== 3'b001) begin errors++; $display("FAIL lat_rd_onehot: got %b want 001", rdv); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_t1_valid: got %b want 0", out_valid); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_t2_valid: got %b want 1", out_valid); end
      checks++; if (out_data !== 16'h1234) begin errors++; $display("FAIL lat_data: got %h want 1234", out_data); end
      checks++; if (out_lane !== 2'd0) begin errors++; $display("FAIL lat_lane: got %0d want 0", out_lane); end
   endtask

   task automatic test_stall();
      logic [RW-1:0] d; logic [1:0] l; bit ok;
      apply_reset();
      push(0, 16'hBEEF);
      push(1, 16'hCAFE);
      pulse_start();
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c%0d: got %b want 1", c, out_valid); end
         checks++; if (out_data !== 16'hBEEF) begin errors++; $display("FAIL stall_data c%0d: got %h want beef", c, out_data); end
         checks++; if ({obf2_rd_en, obf1_rd_en, obf0_rd_en} !== 3'b000) begin errors++;
            $display("FAIL stall_rd_en c%0d: got %b want 000", c, {obf2_rd_en, obf1_rd_en, obf0_rd_en}); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      wait_word(d, l, ok);
      checks++; if ({ok, l, d} !== {1'b1, 2'd1, 16'hCAFE}) begin errors++;
         $display("FAIL stall_next: got ok=%b lane=%0d data=%h want ok=1 lane=1 data=cafe", ok, l, d); end
   endtask

   task automatic test_skip();
      logic [RW-1:0] d; logic [1:0] l; bit ok;
      logic [RW-1:0] exp_d [4];
      logic [1:0] exp_l [4];
      exp_d = '{16'h0A01, 16'h0C01, 16'h0A02, 16'h0C02};
      exp_l = '{2'd0, 2'd2, 2'd0, 2'd2};
      apply_reset();
      push(0, 16'h0A01); push(0, 16'h0A02);
      push(2, 16'h0C01); push(2, 16'h0C02);
      out_ready = 1'b1;
      pulse_start();
      for (int n = 0; n < 4; n++) begin
         wait_word(d, l, ok);
         checks++; if ({ok, l, d} !== {1'b1, exp_l[n], exp_d[n]}) begin errors++;
            $display("FAIL skip_word%0d: got ok=%b lane=%0d data=%h want lane=%0d data=%h", n, ok, l, d, exp_l[n], exp_d[n]); end
      end
      push(1, 16'h0B01);
      wait_word(d, l, ok);
      checks++; if ({ok, l, d} !== {1'b1, 2'd1, 16'h0B01}) begin errors++;
         $display("FAIL skip_late_lane1: got ok=%b lane=%0d data=%h want lane=1 data=0b01", ok, l, d); end
   endtask

   task automatic test_saturate();
      logic [RW-1:0] d, ed; logic [1:0] l, el; bit ok;
      int base;
      apply_reset();
      for (int i = 0; i < 11; i++) push(0, 16'h1000 + RW'(i));
      for (int i = 0; i < 9; i++) push(1, 16'h2000 + RW'(i));
      out_ready = 1'b1;
      pulse_start();
      for (int n = 0; n < 18; n++) begin
         wait_word(d, l, ok);
         el = 2'(n % 2);
         ed = ((n % 2) == 0 ? 16'h1000 : 16'h2000) + RW'(n / 2);
         checks++; if ({ok, l, d} !== {1'b1, el, ed}) begin errors++;
            $display("FAIL sat_word%0d: got ok=%b lane=%0d data=%h want lane=%0d data=%h", n, ok, l, d, el, ed); end
      end
      base = rd0_cnt;
      repeat (20) @(negedge clk);
      checks++; if (rd0_cnt - base !== 0) begin errors++; $display("FAIL sat_full_lane0_reads: got %0d want 0", rd0_cnt - base); end
      checks++; if ({busy, out_valid} !== 2'b10) begin errors++;
         $display("FAIL sat_idle_poll: got busy=%b valid=%b want busy=1 valid=0", busy, out_valid); end
      for (int i = 0; i < 9; i++) push(2, 16'h3000 + RW'(i));
      for (int n = 0; n < 9; n++) begin
         wait_word(d, l, ok);
         ed = 16'h3000 + RW'(n);
         checks++; if ({ok, l, d} !== {1'b1, 2'd2, ed}) begin errors++;
            $display("FAIL sat_lane2_word%0d: got ok=%b lane=%0d data=%h want lane=2 data=%h", n, ok, l, d, ed); end
      end
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL sat_done: got %b want 1", done); end
   endtask

   task automatic test_full_drain();
      logic [RW-1:0] d, ed; logic [1:0] l, el; bit ok;
      int base;
      apply_reset();
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 9; i++) push(k, 16'hA000 + RW'(k * 256 + i));
      base = done_cnt;
      out_ready = 1'b1;
      pulse_start();
      for (int n = 0; n < 27; n++) begin
         wait_word(d, l, ok);
         el = 2'(n % 3);
         ed = 16'hA000 + RW'((n % 3) * 256 + n / 3);
         checks++; if ({ok, l, d} !== {1'b1, el, ed}) begin errors++;
            $display("FAIL drain_word%0d: got ok=%b lane=%0d data=%h want lane=%0d data=%h", n, ok, l, d, el, ed); end
      end
      @(negedge clk);
      checks++; if ({done, busy} !== 2'b10) begin errors++;
         $display("FAIL drain_done: got done=%b busy=%b want done=1 busy=0", done, busy); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL drain_done_pulse: got %b want 0", done); end
      checks++; if (done_cnt - base !== 1) begin errors++; $display("FAIL drain_done_count: got %0d want 1", done_cnt - base); end
   endtask

   task automatic test_reset_mid();
      logic [RW-1:0] d, ed; logic [1:0] l, el; bit ok;
      int base;
      apply_reset();
      push(0, 16'h5555); push(1, 16'h6666);
      out_ready = 1'b1;
      base = done_cnt;
      pulse_start();
      for (int i = 0; i < 20 && !obf0_rd_en; i++) @(negedge clk);
      @(negedge clk);
      checks++; if ({busy, out_valid} !== 2'b10) begin errors++;
         $display("FAIL rmid_in_wait: got busy=%b valid=%b want busy=1 valid=0", busy, out_valid); end
      rst_n = 1'b0;
      #1;
      checks++; if ({busy, out_valid, done, out_lane, out_data} !== 21'h0) begin errors++;
         $display("FAIL rmid_async: got busy=%b valid=%b done=%b lane=%0d data=%h want all 0", busy, out_valid, done, out_lane, out_data); end
      checks++; if ({obf2_rd_en, obf1_rd_en, obf0_rd_en} !== 3'b000) begin errors++;
         $display("FAIL rmid_rd_en: got %b want 000", {obf2_rd_en, obf1_rd_en, obf0_rd_en}); end
      @(negedge clk);
      for (int k = 0; k < 3; k++) wr_ptr[k] = rd_ptr[k];
      rst_n = 1'b1;
      checks++; if (done_cnt - base !== 0) begin errors++; $display("FAIL rmid_no_done: got %0d want 0", done_cnt - base); end
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 9; i++) push(k, 16'hD000 + RW'(k * 256 + i));
      pulse_start();
      for (int n = 0; n < 27; n++) begin
         wait_word(d, l, ok);
         el = 2'(n % 3);
         ed = 16'hD000 + RW'((n % 3) * 256 + n / 3);
         checks++; if ({ok, l, d} !== {1'b1, el, ed}) begin errors++;
            $display("FAIL rmid_word%0d: got ok=%b lane=%0d data=%h want lane=%0d data=%h", n, ok, l, d, el, ed); end
      end
      @(negedge clk);
      @(negedge clk);
      checks++; if (done_cnt - base !== 1) begin errors++; $display("FAIL rmid_done_count: got %0d want 1", done_cnt - base); end
   endtask

   task automatic test_err();
      apply_reset();
      @(negedge clk); obf2_err = 1'b1;
      @(negedge clk); obf2_err = 1'b0;
      checks++; if (err_flag !== ERR_EN) begin errors++; $display("FAIL err_set: got %b want %b", err_flag, ERR_EN); end
      repeat (3) @(negedge clk);
      checks++; if (err_flag !== ERR_EN) begin errors++; $display("FAIL err_sticky: got %b want %b", err_flag, ERR_EN); end
      pulse_start();
      checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL err_clear_on_start: got %b want 0", err_flag); end
   endtask

   task automatic test_protocol();
      checks++; if (viol !== 0) begin errors++; $display("FAIL rd_en_protocol: got %0d violations want 0", viol); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_latency();
      test_stall();
      test_skip();
      test_saturate();
      test_full_drain();
      test_reset_mid();
      test_err();
      test_protocol();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/obf_drain.md
OBF_DRAIN -- requirements
Module: obf_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the input-operand width; result width = 2*DATA_WIDTH.
REQ-002 SHALL have parameter OUT_PER_LANE, default 9, giving the number of results drained per lane per job.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle pulse that begins a job; sampled only in IDLE.
REQ-006 SHALL have ports obf0_empty, obf1_empty, obf2_empty  input  1 each  output-FIFO empty flags.
REQ-007 SHALL have ports obf0_out, obf1_out, obf2_out  input  2*DATA_WIDTH each  output-FIFO read data.
REQ-008 SHALL have ports obf0_err, obf1_err, obf2_err  input  1 each  output-FIFO error flags.
REQ-009 SHALL have ports obf0_rd_en, obf1_rd_en, obf2_rd_en  output  1 each  output-FIFO read strobes.
REQ-010 SHALL have port out_data  output  2*DATA_WIDTH  drained result word.
REQ-011 SHALL have port out_lane  output  2  source lane of out_data (0..2).
REQ-012 SHALL have port out_valid  output  1  out_data/out_lane valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-014 SHALL have ports busy, done, err_flag  output  1 each  job active, single-cycle job-complete pulse, and sticky FIFO error.

Function
REQ-015 SHALL implement the states IDLE, POLL, WAIT, SEND.
REQ-016 In IDLE with start=1, SHALL clear the three lane counters, set lane pointer=0, and enter POLL.
REQ-017 In POLL, if the pointed lane has empty=0 and counter<OUT_PER_LANE, SHALL assert only that lane's rd_en for exactly this cycle and enter WAIT; otherwise it SHALL advance the pointer (2 wraps to 0) and stay in POLL, asserting no rd_en.
REQ-018 The FIFO data SHALL be treated as valid the cycle after rd_en; in WAIT it SHALL register obfN_out into out_data and the pointer into out_lane, then enter SEND.
REQ-019 Latency SHALL be fixed: rd_en in cycle T gives out_valid=1 from cycle T+2.
REQ-020 In SEND, SHALL hold out_valid=1 with out_data/out_lane stable until out_ready=1; on that handshake it SHALL increment the lane counter and advance the pointer.
REQ-021 After a handshake that makes all three counters equal OUT_PER_LANE, SHALL pulse done for one cycle and enter IDLE; otherwise SHALL enter POLL.
REQ-022 busy SHALL be 1 in every state except IDLE; out_valid SHALL be 1 only in SEND.
REQ-023 At most one rd_en SHALL be high per cycle, and never outside POLL.
REQ-024 start SHALL be ignored outside IDLE.
REQ-025 Counters SHALL saturate at OUT_PER_LANE; a full lane SHALL be skipped even when its FIFO is non-empty.
REQ-026 Lane order SHALL be round-robin: after serving lane k, the next lane considered is (k+1) mod 3.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, pointer=0, counters=0, out_data=0, out_lane=0, out_valid=0, all rd_en=0, busy=0, done=0, err_flag=0.
REQ-028 Reset mid-job SHALL abandon the job; a word held in SEND is lost, and no done pulse is issued.

Configuration
REQ-029 With macro OBF_DRAIN_ERR_EN defined, err_flag SHALL be set the cycle after any obfN_err=1, and it SHALL stay set until a start accepted in IDLE or a reset.
REQ-030 Without OBF_DRAIN_ERR_EN, err_flag SHALL be constant 0 and obfN_err SHALL be ignored.

Verification
REQ-031 With OUT_PER_LANE=9, all FIFOs preloaded with 9 words, out_ready=1, and a start pulse -> 27 words appear with lane order 0,1,2,0,1,2... and done pulses once after the 27th handshake.
REQ-032 With the lane-0 FIFO holding 0x1234, rd_en at cycle T -> out_valid=1 at T+2 with out_data=0x1234 and out_lane=0.
REQ-033 With out_ready=0 for 5 cycles while in SEND -> out_valid stays 1, data stays stable, and no rd_en is asserted.
REQ-034 With lane 1 empty and lanes 0 and 2 non-empty -> lane 1 is skipped, the words come from lanes 0 and 2 alternately, and lane 1 is served once it becomes non-empty.
REQ-035 Assert rst_n=0 during WAIT -> all outputs return to their reset values asynchronously, and a new start after reset drains correctly.
REQ-036 With OBF_DRAIN_ERR_EN defined, a one-cycle pulse on obf2_err -> err_flag=1 until the next accepted start; without the macro, err_flag stays 0.
